// File: rtl/os_tile_sequencer_if.sv
// Bundle between the host/DMA control side and the tile sequencer.
// master : host side; drives start/abort, problem configuration and the bias stream.
// slave  : sequencer side; drives the systolic_system controls and the status outputs.
// Groups:
//   control  : start, abort
//   config   : cfg_m/k/n, a/w/o_base, a/w/o_stride
//   bias     : bias_data, bias_valid, bias_ready
//   array    : a/w_buf_on, a/w/o_base_addr, a_num_rows, w_num_cols, mode,
//              operation_signal_in, w_index_bias, w_data_bias, w_en_bias, o_ag_o_on, M, K, N
//   status   : busy, done, err, tile_row, tile_col
interface os_tile_sequencer_if #(
  parameter int ARRAY_N    = 16,
  parameter int ARRAY_M    = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int DIM_WIDTH  = 32,
  parameter int BIAS_WIDTH = 32
);
  localparam int RW = $clog2(ARRAY_N) + 1;
  localparam int CW = $clog2(ARRAY_M) + 1;

  logic                  start;
  logic                  abort;
  logic [DIM_WIDTH-1:0]  cfg_m, cfg_k, cfg_n;
  logic [ADDR_WIDTH-1:0] a_base, w_base, o_base;
  logic [ADDR_WIDTH-1:0] a_stride, w_stride, o_stride;
  logic [BIAS_WIDTH-1:0] bias_data;
  logic                  bias_valid;
  logic                  bias_ready;

  logic                  a_buf_on, w_buf_on;
  logic [ADDR_WIDTH-1:0] a_base_addr, w_base_addr, o_base_addr;
  logic [RW-1:0]         a_num_rows;
  logic [CW-1:0]         w_num_cols;
  logic                  mode;
  logic [2:0]            operation_signal_in;
  logic [CW-1:0]         w_index_bias;
  logic [BIAS_WIDTH-1:0] w_data_bias;
  logic                  w_en_bias;
  logic                  o_ag_o_on;
  logic [DIM_WIDTH-1:0]  M, K, N;
  logic                  busy, done, err;
  logic [15:0]           tile_row, tile_col;

  modport master (
    output start, abort, cfg_m, cfg_k, cfg_n, a_base, w_base, o_base,
           a_stride, w_stride, o_stride, bias_data, bias_valid,
    input  bias_ready, a_buf_on, w_buf_on, a_base_addr, w_base_addr, o_base_addr,
           a_num_rows, w_num_cols, mode, operation_signal_in, w_index_bias,
           w_data_bias, w_en_bias, o_ag_o_on, M, K, N, busy, done, err,
           tile_row, tile_col
  );

  modport slave (
    input  start, abort, cfg_m, cfg_k, cfg_n, a_base, w_base, o_base,
           a_stride, w_stride, o_stride, bias_data, bias_valid,
    output bias_ready, a_buf_on, w_buf_on, a_base_addr, w_base_addr, o_base_addr,
           a_num_rows, w_num_cols, mode, operation_signal_in, w_index_bias,
           w_data_bias, w_en_bias, o_ag_o_on, M, K, N, busy, done, err,
           tile_row, tile_col
  );
endinterface

// File: rtl/os_tile_sequencer.sv
// Output-stationary GEMM tile sequencer for systolic_system.
// Walks C = A(MxK) * W(KxN) in ARRAY_N x ARRAY_M tiles, row-major over tiles.
// For each tile: load per-column bias, then flow -> skew -> drain wait -> store.
// Ports:
//   clk   : clock
//   reset : asynchronous active-low reset
//   bus   : os_tile_sequencer_if.slave (control, config, bias stream, array controls, status)
//
// state      | meaning
// S_IDLE     | waiting for start; all outputs low
// S_BIAS     | accepting one bias word per tile column
// S_FLOW     | K cycles streaming A and W buffers (op 100)
// S_SKEW     | rows+cols-1 cycles letting the wavefront finish (op 100)
// S_DRAIN    | ARRAY_N-rows-1 cycles of drain wait (op 110); skipped when 0
// S_STORE    | rows+1 cycles with the output address generator on (op 110)
// S_NEXT     | advance tile indices and bases; finish or start next tile
module os_tile_sequencer #(
  parameter int ARRAY_N    = 16,
  parameter int ARRAY_M    = 16,
  parameter int ADDR_WIDTH = 10,
  parameter int DIM_WIDTH  = 32,
  parameter int BIAS_WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  os_tile_sequencer_if.slave bus
);
  localparam int RW = $clog2(ARRAY_N) + 1;
  localparam int CW = $clog2(ARRAY_M) + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_BIAS, S_FLOW, S_SKEW, S_DRAIN, S_STORE, S_NEXT
  } state_t;

  state_t                r_state;
  logic [DIM_WIDTH-1:0]  r_cnt;
  logic [CW-1:0]         r_bias_cnt;
  logic [DIM_WIDTH-1:0]  r_rem_m, r_rem_n;
  logic [DIM_WIDTH-1:0]  r_n_cfg, r_k;
  logic [RW-1:0]         r_rows;
  logic [CW-1:0]         r_cols;
  logic [ADDR_WIDTH-1:0] r_a_addr, r_w_addr, r_o_addr;
  logic [ADDR_WIDTH-1:0] r_w_base, r_a_stride, r_w_stride, r_o_stride;
  logic [15:0]           r_tile_row, r_tile_col;
  logic                  r_bias_ready, r_buf_on, r_busy, r_o_ag;
  logic [2:0]            r_op;
  logic                  r_done, r_err, r_w_en_bias;
  logic [CW-1:0]         r_w_index_bias;
  logic [BIAS_WIDTH-1:0] r_w_data_bias;

  logic                  w_last_col, w_last_row, w_zero_dim, w_clear;
  logic [DIM_WIDTH-1:0]  w_rem_m_nx, w_rem_n_nx;

  function automatic logic [RW-1:0] fit_rows(input logic [DIM_WIDTH-1:0] v);
    if (v >= DIM_WIDTH'(ARRAY_N)) return RW'(ARRAY_N);
    return v[RW-1:0];
  endfunction

  function automatic logic [CW-1:0] fit_cols(input logic [DIM_WIDTH-1:0] v);
    if (v >= DIM_WIDTH'(ARRAY_M)) return CW'(ARRAY_M);
    return v[CW-1:0];
  endfunction

  // Remaining rows/cols from the current tile origin replace ceil() tile counts:
  // the tile is the last one in its dimension when the remainder fits the array.
  assign w_last_col  = (r_rem_n <= DIM_WIDTH'(ARRAY_M));
  assign w_last_row  = (r_rem_m <= DIM_WIDTH'(ARRAY_N));
  assign w_rem_m_nx  = r_rem_m - DIM_WIDTH'(ARRAY_N);
  assign w_rem_n_nx  = r_rem_n - DIM_WIDTH'(ARRAY_M);
  assign w_zero_dim  = (bus.cfg_m == '0) || (bus.cfg_k == '0) || (bus.cfg_n == '0);
  // Abort and normal completion both land in IDLE with everything cleared;
  // only completion raises done.
  assign w_clear     = bus.abort || ((r_state == S_NEXT) && w_last_col && w_last_row);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_bias_cnt     <= '0;
      r_rem_m        <= '0;
      r_rem_n        <= '0;
      r_n_cfg        <= '0;
      r_k            <= '0;
      r_rows         <= '0;
      r_cols         <= '0;
      r_a_addr       <= '0;
      r_w_addr       <= '0;
      r_o_addr       <= '0;
      r_w_base       <= '0;
      r_a_stride     <= '0;
      r_w_stride     <= '0;
      r_o_stride     <= '0;
      r_tile_row     <= '0;
      r_tile_col     <= '0;
      r_bias_ready   <= 1'b0;
      r_buf_on       <= 1'b0;
      r_busy         <= 1'b0;
      r_o_ag         <= 1'b0;
      r_op           <= 3'b000;
      r_done         <= 1'b0;
      r_err          <= 1'b0;
      r_w_en_bias    <= 1'b0;
      r_w_index_bias <= '0;
      r_w_data_bias  <= '0;
    end else if (w_clear) begin
      r_state        <= S_IDLE;
      r_cnt          <= '0;
      r_bias_cnt     <= '0;
      r_rem_m        <= '0;
      r_rem_n        <= '0;
      r_k            <= '0;
      r_rows         <= '0;
      r_cols         <= '0;
      r_a_addr       <= '0;
      r_w_addr       <= '0;
      r_o_addr       <= '0;
      r_tile_row     <= '0;
      r_tile_col     <= '0;
      r_bias_ready   <= 1'b0;
      r_buf_on       <= 1'b0;
      r_busy         <= 1'b0;
      r_o_ag         <= 1'b0;
      r_op           <= 3'b000;
      r_done         <= ~bus.abort;
      r_err          <= 1'b0;
      r_w_en_bias    <= 1'b0;
      r_w_index_bias <= '0;
      r_w_data_bias  <= '0;
    end else begin
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_w_en_bias <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            if (w_zero_dim) begin
              r_err <= 1'b1;
            end else begin
              r_state      <= S_BIAS;
              r_busy       <= 1'b1;
              r_bias_ready <= 1'b1;
              r_bias_cnt   <= '0;
              r_rem_m      <= bus.cfg_m;
              r_rem_n      <= bus.cfg_n;
              r_n_cfg      <= bus.cfg_n;
              r_k          <= bus.cfg_k;
              r_rows       <= fit_rows(bus.cfg_m);
              r_cols       <= fit_cols(bus.cfg_n);
              r_a_addr     <= bus.a_base;
              r_w_addr     <= bus.w_base;
              r_o_addr     <= bus.o_base;
              r_w_base     <= bus.w_base;
              r_a_stride   <= bus.a_stride;
              r_w_stride   <= bus.w_stride;
              r_o_stride   <= bus.o_stride;
              r_tile_row   <= '0;
              r_tile_col   <= '0;
            end
          end
        end
        S_BIAS: begin
          if (r_bias_ready && bus.bias_valid) begin
            r_w_en_bias    <= 1'b1;
            r_w_index_bias <= r_bias_cnt;
            r_w_data_bias  <= bus.bias_data;
            r_bias_cnt     <= r_bias_cnt + CW'(1);
            if (r_bias_cnt + CW'(1) == r_cols) begin
              r_bias_ready <= 1'b0;
              r_state      <= S_FLOW;
              r_buf_on     <= 1'b1;
              r_op         <= 3'b100;
              r_cnt        <= r_k - DIM_WIDTH'(1);
            end
          end
        end
        S_FLOW: begin
          if (r_cnt == '0) begin
            r_state  <= S_SKEW;
            r_buf_on <= 1'b0;
            r_cnt    <= DIM_WIDTH'(r_rows) + DIM_WIDTH'(r_cols) - DIM_WIDTH'(2);
          end else begin
            r_cnt <= r_cnt - DIM_WIDTH'(1);
          end
        end
        S_SKEW: begin
          if (r_cnt == '0) begin
            r_op <= 3'b110;
            if (r_rows < RW'(ARRAY_N - 1)) begin
              r_state <= S_DRAIN;
              r_cnt   <= DIM_WIDTH'(ARRAY_N - 2) - DIM_WIDTH'(r_rows);
            end else begin
              r_state <= S_STORE;
              r_o_ag  <= 1'b1;
              r_cnt   <= DIM_WIDTH'(r_rows);
            end
          end else begin
            r_cnt <= r_cnt - DIM_WIDTH'(1);
          end
        end
        S_DRAIN: begin
          if (r_cnt == '0) begin
            r_state <= S_STORE;
            r_o_ag  <= 1'b1;
            r_cnt   <= DIM_WIDTH'(r_rows);
          end else begin
            r_cnt <= r_cnt - DIM_WIDTH'(1);
          end
        end
        S_STORE: begin
          if (r_cnt == '0) begin
            r_state <= S_NEXT;
            r_o_ag  <= 1'b0;
            r_op    <= 3'b000;
          end else begin
            r_cnt <= r_cnt - DIM_WIDTH'(1);
          end
        end
        S_NEXT: begin
          // Final tile is handled by w_clear; here another tile always follows.
          // Tiles are visited in linear order, so the output base just steps by o_stride.
          r_state      <= S_BIAS;
          r_bias_ready <= 1'b1;
          r_bias_cnt   <= '0;
          r_o_addr     <= r_o_addr + r_o_stride;
          if (w_last_col) begin
            r_tile_col <= '0;
            r_tile_row <= r_tile_row + 16'd1;
            r_rem_n    <= r_n_cfg;
            r_rem_m    <= w_rem_m_nx;
            r_rows     <= fit_rows(w_rem_m_nx);
            r_cols     <= fit_cols(r_n_cfg);
            r_a_addr   <= r_a_addr + r_a_stride;
            r_w_addr   <= r_w_base;
          end else begin
            r_tile_col <= r_tile_col + 16'd1;
            r_rem_n    <= w_rem_n_nx;
            r_cols     <= fit_cols(w_rem_n_nx);
            r_w_addr   <= r_w_addr + r_w_stride;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.bias_ready          = r_bias_ready;
  assign bus.a_buf_on            = r_buf_on;
  assign bus.w_buf_on            = r_buf_on;
  assign bus.a_base_addr         = r_a_addr;
  assign bus.w_base_addr         = r_w_addr;
  assign bus.o_base_addr         = r_o_addr;
  assign bus.a_num_rows          = r_rows;
  assign bus.w_num_cols          = r_cols;
  assign bus.mode                = r_busy;
  assign bus.operation_signal_in = r_op;
  assign bus.w_index_bias        = r_w_index_bias;
  assign bus.w_data_bias         = r_w_data_bias;
  assign bus.w_en_bias           = r_w_en_bias;
  assign bus.o_ag_o_on           = r_o_ag;
  assign bus.M                   = DIM_WIDTH'(r_rows);
  assign bus.K                   = r_k;
  assign bus.N                   = DIM_WIDTH'(r_cols);
  assign bus.busy                = r_busy;
  assign bus.done                = r_done;
  assign bus.err                 = r_err;
  assign bus.tile_row            = r_tile_row;
  assign bus.tile_col            = r_tile_col;
endmodule

// File: tb/tb_os_tile_sequencer.sv
module tb_os_tile_sequencer;
  localparam int AN = 16, AM = 16, AW = 10, DW = 32, BW = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  os_tile_sequencer_if #(.ARRAY_N(AN), .ARRAY_M(AM), .ADDR_WIDTH(AW),
                         .DIM_WIDTH(DW), .BIAS_WIDTH(BW)) bus ();

  os_tile_sequencer #(.ARRAY_N(AN), .ARRAY_M(AM), .ADDR_WIDTH(AW),
                      .DIM_WIDTH(DW), .BIAS_WIDTH(BW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int m, k, n;
    int abase, astr, wbase, wstr, obase, ostr;
    int pat;        // 0: bias always valid, 1: valid 1,0,0 repeating
    int sbusy;      // pulse start during the first FLOW cycle
    int exp_err;
    int exp_tiles;
    int exp_busy;   // busy cycles excluding bias stalls
  } vec_t;

  localparam int NV = 9;
  vec_t vecs[NV];

  task automatic set_cfg(input int m, k, n, ab, as_, wb, ws, ob, os_);
    bus.cfg_m = DW'(m); bus.cfg_k = DW'(k); bus.cfg_n = DW'(n);
    bus.a_base = AW'(ab); bus.a_stride = AW'(as_);
    bus.w_base = AW'(wb); bus.w_stride = AW'(ws);
    bus.o_base = AW'(ob); bus.o_stride = AW'(os_);
  endtask

  task automatic run_vec(input int id, input vec_t v);
    int t, tr, tc, ntn, rows, cols, dr, hs;
    int flow_c, skew_c, drain_c, store_c, busy_c, stall_c, bad;
    bit pend, prev_oag, hs_nx;
    int pend_idx;
    logic [31:0] pend_data;
    string p;
    t = 0; tr = 0; tc = 0; hs = 0;
    flow_c = 0; skew_c = 0; drain_c = 0; store_c = 0; busy_c = 0; stall_c = 0; bad = 0;
    pend = 0; prev_oag = 0; pend_idx = 0; pend_data = '0;
    ntn = (v.n + AM - 1) / AM;
    set_cfg(v.m, v.k, v.n, v.abase, v.astr, v.wbase, v.wstr, v.obase, v.ostr);
    bus.bias_valid = 1'b0;
    bus.bias_data = '0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    if (v.exp_err != 0) begin
      chk($sformatf("v%0d err_pulse", id), bus.err, 1);
      chk($sformatf("v%0d err_busy", id), bus.busy, 0);
      chk($sformatf("v%0d err_bufs", id), bus.a_buf_on | bus.w_buf_on, 0);
      @(negedge clk);
      chk($sformatf("v%0d err_one_cycle", id), bus.err, 0);
      chk($sformatf("v%0d err_still_idle", id), bus.busy, 0);
      return;
    end
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (bus.done) break;
      rows = (v.m - tr * AN) < AN ? (v.m - tr * AN) : AN;
      cols = (v.n - tc * AM) < AM ? (v.n - tc * AM) : AM;
      dr   = (AN - rows - 1) > 0 ? (AN - rows - 1) : 0;
      p    = $sformatf("v%0d.t%0d", id, t);
      if (bus.w_en_bias !== pend) bad++;
      else if (pend && (bus.w_index_bias != pend_idx || bus.w_data_bias != pend_data)) bad++;
      if (bus.w_buf_on !== bus.a_buf_on || bus.mode !== bus.busy) bad++;
      if (bus.o_ag_o_on && bus.operation_signal_in != 3'b110) bad++;
      if (bus.busy) busy_c++;
      if (bus.a_buf_on) begin
        flow_c++;
        if (flow_c == 1) begin
          chk({p, " tile_row"}, bus.tile_row, tr);
          chk({p, " tile_col"}, bus.tile_col, tc);
          chk({p, " a_num_rows"}, bus.a_num_rows, rows);
          chk({p, " w_num_cols"}, bus.w_num_cols, cols);
          chk({p, " M"}, bus.M, rows);
          chk({p, " N"}, bus.N, cols);
          chk({p, " K"}, bus.K, v.k);
          chk({p, " a_base_addr"}, bus.a_base_addr, (v.abase + tr * v.astr) % 1024);
          chk({p, " w_base_addr"}, bus.w_base_addr, (v.wbase + tc * v.wstr) % 1024);
          chk({p, " o_base_addr"}, bus.o_base_addr, (v.obase + (tr * ntn + tc) * v.ostr) % 1024);
          chk({p, " flow_after_last_hs"}, bus.w_en_bias && (bus.w_index_bias == cols - 1), 1);
          chk({p, " ready_low_in_flow"}, bus.bias_ready, 0);
        end
      end else if (bus.operation_signal_in == 3'b100) begin
        skew_c++;
      end
      if (bus.operation_signal_in == 3'b110 && !bus.o_ag_o_on) drain_c++;
      if (bus.o_ag_o_on) store_c++;
      if (bus.busy && bus.operation_signal_in == 3'b000 && prev_oag) begin
        chk({p, " flow_len"}, flow_c, v.k);
        chk({p, " skew_len"}, skew_c, rows + cols - 1);
        chk({p, " drain_len"}, drain_c, dr);
        chk({p, " store_len"}, store_c, rows + 1);
        chk({p, " bias_handshakes"}, hs, cols);
        chk({p, " per_cycle_errs"}, bad, 0);
        t++;
        tc++;
        if (tc == ntn) begin tc = 0; tr++; end
        hs = 0; flow_c = 0; skew_c = 0; drain_c = 0; store_c = 0; bad = 0;
      end
      prev_oag = bus.o_ag_o_on;
      bus.bias_valid = (v.pat == 0) || (cyc % 3 == 0);
      hs_nx = bus.bias_valid && bus.bias_ready;
      if (bus.bias_ready && !bus.bias_valid) stall_c++;
      pend = hs_nx;
      pend_idx = hs;
      pend_data = 32'hB1A5_0000 + 32'(t * 256 + hs);
      bus.bias_data = pend_data;
      if (hs_nx) hs++;
      bus.start = (v.sbusy != 0) && (t == 0) && (flow_c == 1);
      @(negedge clk);
    end
    bus.start = 1'b0;
    bus.bias_valid = 1'b0;
    chk($sformatf("v%0d done_pulse", id), bus.done, 1);
    chk($sformatf("v%0d tiles", id), t, v.exp_tiles);
    chk($sformatf("v%0d busy_cycles", id), busy_c - stall_c, v.exp_busy);
    chk($sformatf("v%0d idle_at_done", id), {bus.busy, bus.mode, bus.operation_signal_in}, 0);
    @(negedge clk);
    chk($sformatf("v%0d done_one_cycle", id), bus.done, 0);
  endtask

  task automatic kick(input int m, k, n);
    set_cfg(m, k, n, 0, 0, 0, 0, 0, 0);
    bus.bias_valid = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_for(input int sel, output bit ok);
    ok = 0;
    for (int i = 0; i < 300; i++) begin
      if (sel == 0 ? (bus.busy && bus.operation_signal_in == 3'b100 && !bus.a_buf_on)
                   : bus.o_ag_o_on) begin
        ok = 1;
        break;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    bit ok;
    int dcnt, bcnt;
    vecs[0] = '{10, 30, 10,   0,   0,    0,   0,   0,   0, 0, 0, 0, 1,  76};
    vecs[1] = '{20,  8, 40,   5, 100,    7, 300,   0, 256, 0, 0, 0, 6, 367};
    vecs[2] = '{20,  8, 40,   5, 100,    7, 300,   0, 256, 1, 0, 0, 6, 367};
    vecs[3] = '{ 1,  1,  1,   3,   0,    9,   0,  11,   0, 0, 0, 0, 1,  20};
    vecs[4] = '{15,  2, 17, 1000, 50, 1020,  10, 900, 200, 0, 0, 0, 2, 100};
    vecs[5] = '{14,  4,  2,   0,   0,    0,   0,   0,   0, 0, 1, 0, 1,  38};
    vecs[6] = '{33,  1,  1,  10, 700,    0,   0,   0,   5, 1, 0, 0, 3,  92};
    vecs[7] = '{10,  0, 10,   0,   0,    0,   0,   0,   0, 0, 0, 1, 0,   0};
    vecs[8] = '{ 0,  5,  3,   0,   0,    0,   0,   0,   0, 0, 0, 1, 0,   0};

    bus.start = 1'b0; bus.abort = 1'b0; bus.bias_valid = 1'b0; bus.bias_data = '0;
    set_cfg(0, 0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #2 reset = 1'b0;
    #1;
    chk("reset busy", bus.busy, 0);
    chk("reset outputs", {bus.bias_ready, bus.a_buf_on, bus.o_ag_o_on, bus.w_en_bias,
                          bus.operation_signal_in, bus.done, bus.err, bus.mode}, 0);
    chk("reset o_base_addr", bus.o_base_addr, 0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // abort wins over start in IDLE
    set_cfg(4, 4, 4, 0, 0, 0, 0, 0, 0);
    bus.start = 1'b1; bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0; bus.abort = 1'b0;
    chk("abort_over_start busy", bus.busy, 0);

    // abort during SKEW
    kick(10, 4, 10);
    wait_for(0, ok);
    chk("abort reached_skew", ok, 1);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    bus.bias_valid = 1'b0;
    chk("abort busy", bus.busy, 0);
    chk("abort outputs", {bus.mode, bus.operation_signal_in, bus.o_ag_o_on, bus.done}, 0);
    chk("abort geometry", {bus.a_num_rows, bus.w_num_cols, bus.K}, 0);
    dcnt = 0; bcnt = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.done) dcnt++;
      if (bus.busy) bcnt++;
      @(negedge clk);
    end
    chk("abort no_done", dcnt, 0);
    chk("abort stays_idle", bcnt, 0);
    run_vec(100, vecs[0]);

    // asynchronous reset during STORE
    kick(10, 4, 10);
    wait_for(1, ok);
    chk("rst reached_store", ok, 1);
    #2 reset = 1'b0;
    #1;
    chk("rst async o_ag_o_on", bus.o_ag_o_on, 0);
    chk("rst async busy", bus.busy, 0);
    chk("rst async outputs", {bus.mode, bus.operation_signal_in, bus.a_num_rows, bus.tile_row}, 0);
    bus.bias_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_vec(101, vecs[3]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
